alu_exec_stage: RTL

// - Execute stage directly downstream of alu_control: consumes its 3-bit alu_control code plus operands from decode.
// - Computes ALU result, zero flag, branch decision and branch target; results leave in order.
// - valid/ready handshake on both sides; a 2-entry skid buffer gives full throughput under backpressure.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_core.sv | 61 ++++++
 rtl/alu_exec_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU execute stage: opcode encoding,
// skid-buffer states and the per-instruction result entry.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    ALU_AND     = 3'b000,
    ALU_OR      = 3'b001,
    ALU_ADD     = 3'b010,
    ALU_SUB     = 3'b011,
    ALU_BLT     = 3'b100,
    ALU_BGE     = 3'b101,
    ALU_BEQ     = 3'b110,
    ALU_ILLEGAL = 3'b111
  } alu_code_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_HALF  = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [XLEN_DEF-1:0] result;
    logic                zero;
    logic                taken;
    logic [XLEN_DEF-1:0] target;
    logic [4:0]          rd;
    logic                illegal;
  } alu_entry_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: builds one complete result entry from the alu_control
// code, operands, pc and branch offset.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      code,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd,
  output alu_entry_t      entry
);

  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] result;
  logic            taken;
  logic            illegal;

  assign diff = op_a - op_b;

  // Branches reuse the subtractor so out_result carries a - b for them too;
  // an X/Z code falls into default and is reported as illegal.
  always_comb begin
    result  = '0;
    taken   = 1'b0;
    illegal = 1'b0;
    case (alu_code_e'(code))
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      ALU_ADD: result = op_a + op_b;
      ALU_SUB: result = diff;
      ALU_BLT: begin
        result = diff;
        taken  = $signed(op_a) < $signed(op_b);
      end
      ALU_BGE: begin
        result = diff;
        taken  = $signed(op_a) >= $signed(op_b);
      end
      ALU_BEQ: begin
        result = diff;
        taken  = (op_a == op_b);
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    entry         = '0;
    entry.result  = result;
    entry.zero    = (result == '0);
    entry.taken   = taken;
    entry.target  = pc + imm;
    entry.rd      = rd;
    entry.illegal = illegal;
  end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: alu_core feeding a 2-entry skid buffer with valid/ready
// handshakes on both sides; results leave in acceptance order.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   BUF_EMPTY | no entries held, out_valid low
//   BUF_HALF  | head holds one entry
//   BUF_FULL  | head and tail both hold entries, in_ready low
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_alu_control,
  input  logic [XLEN-1:0] in_op_a,
  input  logic [XLEN-1:0] in_op_b,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_branch_taken,
  output logic [XLEN-1:0] out_branch_target,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  buf_state_e state_q, state_d;
  alu_entry_t new_entry, head_q, tail_q;
  logic       push, pop;
  logic       load_head_new, load_tail_new, load_head_tail;

  alu_core #(.XLEN(XLEN)) u_core (
    .code  (in_alu_control),
    .op_a  (in_op_a),
    .op_b  (in_op_b),
    .pc    (in_pc),
    .imm   (in_imm),
    .rd    (in_rd),
    .entry (new_entry)
  );

  assign in_ready  = (state_q != BUF_FULL) && rst_n;
  assign out_valid = (state_q != BUF_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= BUF_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_EMPTY: if (push) state_d = BUF_HALF;
      BUF_HALF: begin
        if (push && !pop)      state_d = BUF_FULL;
        else if (pop && !push) state_d = BUF_EMPTY;
      end
      BUF_FULL:  if (pop) state_d = BUF_HALF;
      default:   state_d = BUF_EMPTY;
    endcase
  end

  // Head always holds the oldest entry; the tail only fills under backpressure.
  always_comb begin
    load_head_new  = 1'b0;
    load_tail_new  = 1'b0;
    load_head_tail = 1'b0;
    case (state_q)
      BUF_EMPTY: load_head_new = push;
      BUF_HALF: begin
        load_head_new = push && pop;
        load_tail_new = push && !pop;
      end
      BUF_FULL:  load_head_tail = pop;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head_new)       head_q <= new_entry;
      else if (load_head_tail) head_q <= tail_q;
      if (load_tail_new)       tail_q <= new_entry;
    end
  end

  assign out_result        = head_q.result;
  assign out_zero          = head_q.zero;
  assign out_branch_taken  = head_q.taken;
  assign out_branch_target = head_q.target;
  assign out_rd            = head_q.rd;
  assign out_illegal       = head_q.illegal;

endmodule
